cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, giving per-source skid FIFO entries (power of two, 2..4).
REQ-002 SHALL have parameter ROB_ID_W, default 4, giving the ROB entry index width.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  in  1  global enable; low = hold all state.
REQ-006 SHALL have port rollback  in  1  misprediction flush.
REQ-007 SHALL have ports alu_config in 1, alu_rob_entry in ROB_ID_W, alu_val in 32, alu_need_jump in 1, alu_jump_pc in 32  ALU result.
REQ-008 SHALL have ports lsb_config in 1, lsb_rob_entry in ROB_ID_W, lsb_value in 32  load/store result.
REQ-009 SHALL have ports alu_stall out 1, lsb_stall out 1  source FIFO full.
REQ-010 SHALL have ports cdb_config out 1, cdb_rob_entry out ROB_ID_W, cdb_value out 32, cdb_need_jump out 1, cdb_jump_pc out 32, cdb_src out 1 (0 ALU, 1 LSB)  single registered broadcast to ROB/RS/LSB.
REQ-011 SHALL have port ovf_err  out  1  sticky: a result arrived while its stall was high.

Function
REQ-012 SHALL issue at most one CDB broadcast per cycle; cdb_* registered, valid for exactly one cycle per result.
REQ-013 Candidate per source SHALL be its FIFO head if non-empty, else its incoming result if config high.
REQ-014 One candidate: SHALL grant it. Both: SHALL grant the source not equal to last_grant. last_grant SHALL update on every grant.
REQ-015 Granted incoming (FIFO empty) SHALL bypass to cdb_* at the same edge: latency 1 edge, config to cdb_config.
REQ-016 Granted FIFO head SHALL pop; an incoming result of that source in the same cycle SHALL push (count unchanged).
REQ-017 Non-granted incoming result SHALL push into its FIFO.
REQ-018 No candidate: cdb_config SHALL be 0 next cycle; other cdb_* fields hold.
REQ-019 For LSB grants cdb_need_jump and cdb_jump_pc SHALL be 0; cdb_value = lsb_value. For ALU grants cdb_value = alu_val.
REQ-020 x_stall SHALL be combinational: count == FIFO_DEPTH.
REQ-021 Incoming result with its stall high SHALL be dropped, set ovf_err; FIFO unchanged.
REQ-022 Order within one source SHALL be preserved; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 rdy low SHALL freeze FIFOs, pointers, last_grant and cdb_*; incoming results ignored.
REQ-024 rollback high at an edge (regardless of rdy) SHALL empty both FIFOs, clear cdb_config, set last_grant = LSB, discard same-cycle incoming results; ovf_err kept.

Reset
REQ-025 On rst low, immediately: cdb_config 0, cdb_rob_entry 0, cdb_value 0, cdb_need_jump 0, cdb_jump_pc 0, cdb_src 0, ovf_err 0, FIFOs empty, stalls 0, last_grant = LSB (ALU wins first contention).
REQ-026 Reset asserted mid-operation SHALL discard all buffered results; first edge after release behaves as idle.

Structure
REQ-027 Shared package SHALL hold ROB_ID_W, source encoding SRC_ALU=0/SRC_LSB=1, default FIFO_DEPTH.
REQ-028 SHALL instantiate sub-module cdb_result_fifo (parameterised width/depth, push/pop/count) twice: ALU 69 bits, LSB 36 bits.
REQ-029 Arbitration and bypass SHALL be in the top module; no other state.

Verification
REQ-030 ALU-only: alu_config, entry 3, val 0x11 -> next cycle cdb_config 1, entry 3, value 0x11, src 0; following cycle cdb_config 0.
REQ-031 Contention: ALU entry 1 and LSB entry 2 same cycle after reset -> ALU broadcast cycle+1, LSB cycle+2; next simultaneous pair -> LSB first.
REQ-032 Backpressure: ALU and LSB driven every cycle 6 cycles -> broadcasts alternate, each FIFO reaches 2, stall asserts, no ovf_err if producers obey stall.
REQ-033 Overflow: ALU driven ignoring alu_stall -> ovf_err 1, dropped entry never broadcast, order of others intact.
REQ-034 Rollback with both FIFOs holding 2 -> next cycle cdb_config 0, stalls 0, nothing from pre-flush broadcast later.
REQ-035 rdy low 3 cycles with pending FIFO entries -> cdb_* frozen, no pop; resumes in order when rdy high.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and source encoding for the CDB arbiter slice.
// Result widths are derived from the ROB index width.
package cdb_arbiter_pkg;

    localparam int ROB_ID_W       = 4;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

    function automatic int alu_rec_w(input int rw);
        return rw + 65;
    endfunction

    function automatic int lsb_rec_w(input int rw);
        return rw + 32;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Small per-source skid FIFO; depth is a power of two so pointers wrap.
// Flush empties it at the next edge and has priority over push/pop.
module cdb_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Two-source common data bus arbiter: alternating priority on contention,
// same-edge bypass when a source queue is empty, skid FIFOs otherwise.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ROB_ID_W   = cdb_arbiter_pkg::ROB_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                alu_config,
    input  logic [ROB_ID_W-1:0] alu_rob_entry,
    input  logic [31:0]         alu_val,
    input  logic                alu_need_jump,
    input  logic [31:0]         alu_jump_pc,
    input  logic                lsb_config,
    input  logic [ROB_ID_W-1:0] lsb_rob_entry,
    input  logic [31:0]         lsb_value,
    output logic                alu_stall,
    output logic                lsb_stall,
    output logic                cdb_config,
    output logic [ROB_ID_W-1:0] cdb_rob_entry,
    output logic [31:0]         cdb_value,
    output logic                cdb_need_jump,
    output logic [31:0]         cdb_jump_pc,
    output logic                cdb_src,
    output logic                ovf_err
);

    localparam int AW = alu_rec_w(ROB_ID_W);
    localparam int LW = lsb_rec_w(ROB_ID_W);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [AW-1:0] a_din, a_dout, a_sel;
    logic [LW-1:0] l_din, l_dout, l_sel;
    logic [CW-1:0] a_cnt, l_cnt;
    logic          go, a_empty, l_empty;
    logic          a_in, l_in, a_drop, l_drop;
    logic          a_cand, l_cand, g_alu, g_lsb;
    logic          a_push, a_pop, l_push, l_pop;

    logic                cfg_q, cfg_d;
    logic [ROB_ID_W-1:0] ent_q, ent_d;
    logic [31:0]         val_q, val_d;
    logic                nj_q, nj_d;
    logic [31:0]         pc_q, pc_d;
    cdb_src_e            src_q, src_d;
    cdb_src_e            last_q, last_d;
    logic                ovf_q, ovf_d;

    assign go        = rdy & ~rollback;
    assign a_empty   = (a_cnt == '0);
    assign l_empty   = (l_cnt == '0);
    assign alu_stall = (a_cnt == CW'(FIFO_DEPTH));
    assign lsb_stall = (l_cnt == CW'(FIFO_DEPTH));

    assign a_in   = go & alu_config & ~alu_stall;
    assign l_in   = go & lsb_config & ~lsb_stall;
    assign a_drop = go & alu_config & alu_stall;
    assign l_drop = go & lsb_config & lsb_stall;

    assign a_cand = go & (~a_empty | a_in);
    assign l_cand = go & (~l_empty | l_in);
    assign g_alu  = a_cand & (~l_cand | (last_q == SRC_LSB));
    assign g_lsb  = l_cand & ~g_alu;

    // A granted incoming result only skips the queue when nothing is ahead of it
    assign a_pop  = g_alu & ~a_empty;
    assign a_push = a_in & ~(g_alu & a_empty);
    assign l_pop  = g_lsb & ~l_empty;
    assign l_push = l_in & ~(g_lsb & l_empty);

    assign a_din = {alu_rob_entry, alu_val, alu_need_jump, alu_jump_pc};
    assign l_din = {lsb_rob_entry, lsb_value};
    assign a_sel = a_empty ? a_din : a_dout;
    assign l_sel = l_empty ? l_din : l_dout;

    cdb_result_fifo #(.WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rollback),
        .push  (a_push),
        .pop   (a_pop),
        .din   (a_din),
        .dout  (a_dout),
        .count (a_cnt)
    );

    cdb_result_fifo #(.WIDTH(LW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rollback),
        .push  (l_push),
        .pop   (l_pop),
        .din   (l_din),
        .dout  (l_dout),
        .count (l_cnt)
    );

    always_comb begin
        cfg_d  = cfg_q;
        ent_d  = ent_q;
        val_d  = val_q;
        nj_d   = nj_q;
        pc_d   = pc_q;
        src_d  = src_q;
        last_d = last_q;
        ovf_d  = ovf_q | a_drop | l_drop;
        if (rollback) begin
            cfg_d  = 1'b0;
            last_d = SRC_LSB;
        end else if (rdy) begin
            cfg_d = g_alu | g_lsb;
            if (g_alu) begin
                ent_d  = a_sel[AW-1 -: ROB_ID_W];
                val_d  = a_sel[64:33];
                nj_d   = a_sel[32];
                pc_d   = a_sel[31:0];
                src_d  = SRC_ALU;
                last_d = SRC_ALU;
            end else if (g_lsb) begin
                ent_d  = l_sel[LW-1 -: ROB_ID_W];
                val_d  = l_sel[31:0];
                nj_d   = 1'b0;
                pc_d   = '0;
                src_d  = SRC_LSB;
                last_d = SRC_LSB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q  <= 1'b0;
            ent_q  <= '0;
            val_q  <= '0;
            nj_q   <= 1'b0;
            pc_q   <= '0;
            src_q  <= SRC_ALU;
            last_q <= SRC_LSB;
            ovf_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            ent_q  <= ent_d;
            val_q  <= val_d;
            nj_q   <= nj_d;
            pc_q   <= pc_d;
            src_q  <= src_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cdb_config    = cfg_q;
    assign cdb_rob_entry = ent_q;
    assign cdb_value     = val_q;
    assign cdb_need_jump = nj_q;
    assign cdb_jump_pc   = pc_q;
    assign cdb_src       = src_q;
    assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter: table of per-cycle stimulus with
// hand-computed broadcasts, plus an asynchronous mid-operation reset.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        alu_config;
    logic [3:0]  alu_rob_entry;
    logic [31:0] alu_val;
    logic        alu_need_jump;
    logic [31:0] alu_jump_pc;
    logic        lsb_config;
    logic [3:0]  lsb_rob_entry;
    logic [31:0] lsb_value;
    logic        alu_stall;
    logic        lsb_stall;
    logic        cdb_config;
    logic [3:0]  cdb_rob_entry;
    logic [31:0] cdb_value;
    logic        cdb_need_jump;
    logic [31:0] cdb_jump_pc;
    logic        cdb_src;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    // Last broadcast the bench expects the bus to be holding
    logic [3:0]  h_ent;
    logic [31:0] h_val;
    logic        h_nj;
    logic [31:0] h_pc;
    logic        h_src;

    typedef struct {
        logic r, rb, ac;
        int   ae;
        logic lc;
        int   le;
        logic ec, es;
        int   ee;
        logic eas, els, eov;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .rollback      (rollback),
        .alu_config    (alu_config),
        .alu_rob_entry (alu_rob_entry),
        .alu_val       (alu_val),
        .alu_need_jump (alu_need_jump),
        .alu_jump_pc   (alu_jump_pc),
        .lsb_config    (lsb_config),
        .lsb_rob_entry (lsb_rob_entry),
        .lsb_value     (lsb_value),
        .alu_stall     (alu_stall),
        .lsb_stall     (lsb_stall),
        .cdb_config    (cdb_config),
        .cdb_rob_entry (cdb_rob_entry),
        .cdb_value     (cdb_value),
        .cdb_need_jump (cdb_need_jump),
        .cdb_jump_pc   (cdb_jump_pc),
        .cdb_src       (cdb_src),
        .ovf_err       (ovf_err)
    );

    function automatic logic [31:0] aval(input logic [3:0] e);
        return 32'hA000_0000 | {28'h0, e};
    endfunction

    function automatic logic [31:0] apc(input logic [3:0] e);
        return 32'h0000_4000 + {26'h0, e, 2'b00};
    endfunction

    function automatic logic [31:0] lval(input logic [3:0] e);
        return 32'hB000_0000 | {28'h0, e};
    endfunction

    task automatic drive(input logic r, rb, ac, input int ae,
                         input logic lc, input int le);
        logic [3:0] a4, l4;
        a4 = 4'(ae);
        l4 = 4'(le);
        rdy           = r;
        rollback      = rb;
        alu_config    = ac;
        alu_rob_entry = a4;
        alu_val       = aval(a4);
        alu_need_jump = a4[0];
        alu_jump_pc   = apc(a4);
        lsb_config    = lc;
        lsb_rob_entry = l4;
        lsb_value     = lval(l4);
    endtask

    task automatic clear_hold();
        h_ent = '0;
        h_val = '0;
        h_nj  = 1'b0;
        h_pc  = '0;
        h_src = 1'b0;
    endtask

    task automatic check(input string name, input logic ec, es, input int ee,
                         input logic eas, els, eov);
        logic [3:0]  e4;
        logic [73:0] got, exp;
        e4 = 4'(ee);
        if (ec) begin
            h_ent = e4;
            h_src = es;
            if (es) begin
                h_val = lval(e4);
                h_nj  = 1'b0;
                h_pc  = '0;
            end else begin
                h_val = aval(e4);
                h_nj  = e4[0];
                h_pc  = apc(e4);
            end
        end
        got = {cdb_config, cdb_rob_entry, cdb_value, cdb_need_jump,
               cdb_jump_pc, cdb_src, alu_stall, lsb_stall, ovf_err};
        exp = {ec, h_ent, h_val, h_nj, h_pc, h_src, eas, els, eov};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cfg=%b ent=%h val=%h nj=%b pc=%h src=%b as=%b ls=%b ovf=%b, required %h",
                     name, cdb_config, cdb_rob_entry, cdb_value, cdb_need_jump,
                     cdb_jump_pc, cdb_src, alu_stall, lsb_stall, ovf_err, exp);
        end
    endtask

    task automatic add(input logic r, rb, ac, input int ae, input logic lc,
                       input int le, input logic ec, es, input int ee,
                       input logic eas, els, eov);
        vec_t v;
        v.r = r; v.rb = rb; v.ac = ac; v.ae = ae; v.lc = lc; v.le = le;
        v.ec = ec; v.es = es; v.ee = ee;
        v.eas = eas; v.els = els; v.eov = eov;
        vecs.push_back(v);
    endtask

    initial begin
        // contention right after reset, second pair while LSB still queued
        add(1,0,1,1,1,2,   1,0,1,  0,0,0);
        add(1,0,1,4,1,5,   1,1,2,  0,0,0);
        add(1,0,0,0,0,0,   1,0,4,  0,0,0);
        add(1,0,0,0,0,0,   1,1,5,  0,0,0);
        add(1,0,0,0,0,0,   0,0,0,  0,0,0);
        // single ALU result
        add(1,0,1,3,0,0,   1,0,3,  0,0,0);
        add(1,0,0,0,0,0,   0,0,0,  0,0,0);
        // both producers busy, obeying stall
        add(1,0,1,6,1,7,   1,1,7,  0,0,0);
        add(1,0,1,8,1,9,   1,0,6,  0,0,0);
        add(1,0,1,10,1,11, 1,1,9,  1,0,0);
        add(1,0,0,0,1,12,  1,0,8,  0,1,0);
        add(1,0,1,13,0,0,  1,1,11, 1,0,0);
        add(1,0,0,0,1,14,  1,0,10, 0,1,0);
        // rdy low: everything frozen, inputs ignored
        add(0,0,1,15,1,15, 1,0,10, 0,1,0);
        add(0,0,0,0,0,0,   1,0,10, 0,1,0);
        add(0,0,0,0,0,0,   1,0,10, 0,1,0);
        add(1,0,0,0,0,0,   1,1,12, 0,0,0);
        add(1,0,0,0,0,0,   1,0,13, 0,0,0);
        add(1,0,0,0,0,0,   1,1,14, 0,0,0);
        add(1,0,0,0,0,0,   0,0,0,  0,0,0);
        // ALU ignores stall: entry 8 dropped
        add(1,0,1,1,1,2,   1,0,1,  0,0,0);
        add(1,0,1,3,1,4,   1,1,2,  0,0,0);
        add(1,0,1,5,1,6,   1,0,3,  0,1,0);
        add(1,0,1,7,0,0,   1,1,4,  1,0,0);
        add(1,0,1,8,1,9,   1,0,5,  0,1,1);
        add(1,0,0,0,0,0,   1,1,6,  0,0,1);
        add(1,0,0,0,0,0,   1,0,7,  0,0,1);
        add(1,0,0,0,0,0,   1,1,9,  0,0,1);
        add(1,0,0,0,0,0,   0,0,0,  0,0,1);
        // fill, then rollback with rdy low
        add(1,0,1,1,1,2,   1,0,1,  0,0,1);
        add(1,0,1,3,1,4,   1,1,2,  0,0,1);
        add(1,0,1,5,1,6,   1,0,3,  0,1,1);
        add(1,0,1,7,0,0,   1,1,4,  1,0,1);
        add(0,1,0,0,1,8,   0,0,0,  0,0,1);
        add(1,0,0,0,0,0,   0,0,0,  0,0,1);
        add(1,0,1,9,1,10,  1,0,9,  0,0,1);
        add(1,0,0,0,0,0,   1,1,10, 0,0,1);
        add(1,0,0,0,0,0,   0,0,0,  0,0,1);

        drive(0,0,0,0,0,0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        clear_hold();
        check("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.r, v.rb, v.ac, v.ae, v.lc, v.le);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), v.ec, v.es, v.ee, v.eas, v.els, v.eov);
        end

        // asynchronous reset while LSB entry is buffered
        drive(1,0,1,1,1,2);
        @(posedge clk);
        #1;
        check("pre_rst", 1, 0, 1, 0, 0, 1);
        drive(1,0,0,0,0,0);
        #2 rst = 1'b0;
        #1;
        clear_hold();
        check("async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", 0, 0, 0, 0, 0, 0);
        drive(1,0,1,3,1,4);
        @(posedge clk);
        #1;
        check("post_rst_alu_wins", 1, 0, 3, 0, 0, 0);
        drive(1,0,0,0,0,0);
        @(posedge clk);
        #1;
        check("post_rst_lsb", 1, 1, 4, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
